// File: rtl/framegrabber_s_axi_burst_mem_if.sv
// AXI4 (full) bundle for the framegrabber burst-memory slave.
// Sideband fields are carried so masters can connect them; the slave ignores them.
interface framegrabber_s_axi_burst_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int ID_W   = 1
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic [3:0]          awregion;
   logic                awuser;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic [3:0]          arqos;
   logic [3:0]          arregion;
   logic                aruser;
   logic                arvalid;
   logic                arready;

   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
             awregion, awuser, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
             arregion, aruser, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
             awregion, awuser, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
             arregion, aruser, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/framegrabber_s_axi_burst_mem.sv
// AXI4 slave backed by an on-chip word memory; INCR/FIXED/WRAP bursts, byte strobes,
// SLVERR on illegal bursts, independent read and write engines.
module framegrabber_s_axi_burst_mem #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_MEM_DEPTH_WORDS  = 256
) (
   input logic                               S_AXI_ACLK,
   input logic                               S_AXI_ARESETN,
   framegrabber_s_axi_burst_mem_if.slave     s_axi
);
   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int IDW      = C_S_AXI_ID_WIDTH;
   localparam int NB       = DW / 8;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IDX_W    = $clog2(C_MEM_DEPTH_WORDS);

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OK = 2'b00;
   localparam logic [1:0] RESP_SE = 2'b10;

   logic [DW-1:0] mem [C_MEM_DEPTH_WORDS];

   function automatic logic burst_illegal(input logic [ADDR_LSB-1:0] lsb, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
      logic ill;
      ill = (burst == 2'b11) || (size != 3'(ADDR_LSB));
      if (burst == B_WRAP) begin
         if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ill = 1'b1;
         if (lsb != '0) ill = 1'b1;
      end
      return ill;
   endfunction

   // WRAP windows are len+1 words with len in {1,3,7,15}, so len itself is the in-window mask.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur, input logic [7:0] len,
                                                 input logic [1:0] burst);
      logic [IDX_W-1:0] inc, mask, nxt;
      inc  = cur + IDX_W'(1);
      mask = IDX_W'(len);
      case (burst)
         B_FIXED: nxt = cur;
         B_WRAP:  nxt = (cur & ~mask) | (inc & mask);
         default: nxt = inc;
      endcase
      return nxt;
   endfunction

   // ---------------- write engine ----------------
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   w_state_t         w_state;
   logic             awready_q, wready_q, bvalid_q;
   logic [IDW-1:0]   bid_q, w_id;
   logic [1:0]       bresp_q, w_burst;
   logic [IDX_W-1:0] w_idx;
   logic [7:0]       w_len, w_cnt;
   logic             w_ill, w_lerr, w_fire, w_at_last;

   assign w_fire    = s_axi.wvalid && wready_q;
   assign w_at_last = (w_cnt == w_len);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         w_id      <= '0;
         w_idx     <= '0;
         w_len     <= '0;
         w_burst   <= '0;
         w_cnt     <= '0;
         w_ill     <= 1'b0;
         w_lerr    <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (s_axi.awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_id      <= s_axi.awid;
                  w_idx     <= s_axi.awaddr[ADDR_LSB +: IDX_W];
                  w_len     <= s_axi.awlen;
                  w_burst   <= s_axi.awburst;
                  w_ill     <= burst_illegal(s_axi.awaddr[ADDR_LSB-1:0], s_axi.awlen,
                                             s_axi.awsize, s_axi.awburst);
                  w_lerr    <= 1'b0;
                  w_cnt     <= '0;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_cnt <= w_cnt + 8'd1;
                  w_idx <= next_idx(w_idx, w_len, w_burst);
                  if (s_axi.wlast != w_at_last) w_lerr <= 1'b1;
                  // The beat count, not WLAST, decides when the burst ends.
                  if (w_at_last) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= w_id;
                     bresp_q  <= (w_ill || w_lerr || !s_axi.wlast) ? RESP_SE : RESP_OK;
                     w_state  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (w_fire && !w_ill) begin
         for (int b = 0; b < NB; b++)
            if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
   end

   // ---------------- read engine ----------------
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   r_state_t         r_state;
   logic             arready_q, rvalid_q, rlast_q;
   logic [IDW-1:0]   rid_q, r_id;
   logic [1:0]       rresp_q, r_burst;
   logic [DW-1:0]    rdata_q;
   logic [IDX_W-1:0] r_idx, r_nidx;
   logic [7:0]       r_len, r_cnt;
   logic             r_ill;

   assign r_nidx = next_idx(r_idx, r_len, r_burst);

   // RDATA is prefetched on each handshake so beats stream at one per cycle.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         r_id      <= '0;
         r_idx     <= '0;
         r_len     <= '0;
         r_burst   <= '0;
         r_cnt     <= '0;
         r_ill     <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (s_axi.arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  r_id      <= s_axi.arid;
                  r_idx     <= s_axi.araddr[ADDR_LSB +: IDX_W];
                  r_len     <= s_axi.arlen;
                  r_burst   <= s_axi.arburst;
                  r_ill     <= burst_illegal(s_axi.araddr[ADDR_LSB-1:0], s_axi.arlen,
                                             s_axi.arsize, s_axi.arburst);
                  r_cnt     <= '0;
                  r_state   <= R_ADDR;
               end
            end
            R_ADDR: begin
               rvalid_q <= 1'b1;
               rid_q    <= r_id;
               rresp_q  <= r_ill ? RESP_SE : RESP_OK;
               rdata_q  <= r_ill ? '0 : mem[r_idx];
               rlast_q  <= (r_len == 8'd0);
               r_state  <= R_DATA;
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     r_idx   <= r_nidx;
                     r_cnt   <= r_cnt + 8'd1;
                     rdata_q <= r_ill ? '0 : mem[r_nidx];
                     rlast_q <= ((r_cnt + 8'd1) == r_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   logic unused_sideband;
   assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                              s_axi.awregion, s_axi.awuser, s_axi.awaddr,
                              s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                              s_axi.arregion, s_axi.aruser, s_axi.araddr};
endmodule
